// File: rtl/phy_64b66b_pkg.sv
// Shared 64b/66b framing constants, block types and FSM encoding for the PHY TX/RX pair.
package phy_64b66b_pkg;

  localparam int unsigned BLK_W  = 64;
  localparam int unsigned HDR_W  = 2;
  localparam int unsigned SEQ_W  = 7;
  localparam int unsigned KEEP_W = 8;

  localparam logic [HDR_W-1:0] HDR_DATA = 2'b01;
  localparam logic [HDR_W-1:0] HDR_CTRL = 2'b10;

  localparam logic [7:0] BT_SOF  = 8'h71;
  localparam logic [7:0] BT_IDLE = 8'h1E;

  // Terminate block type indexed by the number of trailing data bytes it carries.
  localparam logic [7:0] BT_TERM [0:7] = '{8'h8E, 8'h99, 8'hA5, 8'hB2,
                                           8'hC3, 8'hD4, 8'hE8, 8'hFF};

  localparam logic [SEQ_W-1:0] SEQ_MAX = 7'd32;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_DATA  = 3'd1,
    ST_TERM0 = 3'd2,
    ST_TERM1 = 3'd3,
    ST_GAP   = 3'd4
  } tx_state_e;

  typedef struct packed {
    logic [HDR_W-1:0] hdr;
    logic [BLK_W-1:0] data;
  } blk66_t;

  // Big-endian beat (byte0 in [63:56]) to wire order (byte0 in [7:0]).
  function automatic logic [BLK_W-1:0] swap_bytes(input logic [BLK_W-1:0] v);
    logic [BLK_W-1:0] r;
    for (int i = 0; i < 8; i++) begin
      r[8*i +: 8] = v[56-8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/phy_tx_seq_cnt.sv
// GT external gearbox sequence counter (0..SEQ_MAX) with current and next-cycle pause flags.
module phy_tx_seq_cnt
  import phy_64b66b_pkg::*;
(
  input  logic             i_clk,
  input  logic             i_rst,
  output logic [SEQ_W-1:0] o_seq,
  output logic             o_pause_c,
  output logic             o_pause_next_c
);

  logic [SEQ_W-1:0] seq_q;
  logic [SEQ_W-1:0] seq_d;

  always_comb begin
    seq_d = (seq_q == SEQ_MAX) ? '0 : seq_q + SEQ_W'(1);
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      seq_q <= '0;
    end else begin
      seq_q <= seq_d;
    end
  end

  assign o_seq          = seq_q;
  assign o_pause_c      = (seq_q == SEQ_MAX);
  assign o_pause_next_c = (seq_d == SEQ_MAX);

endmodule

// File: rtl/phy_tx.sv
// 64b/66b transmit framer: big-endian AXI-Stream frames to 66b blocks for the GT TX gearbox.
// Frame bytes are skewed by one so SOF carries bytes 0..6; byte 7 of each beat rides in the residual.
module phy_tx
  import phy_64b66b_pkg::*;
#(
  parameter int unsigned MIN_IPG = 1
)
(
  input  logic              i_tx_clk,
  input  logic              i_tx_rst,
  input  logic [BLK_W-1:0]  s_axis_data,
  input  logic [KEEP_W-1:0] s_axis_keep,
  input  logic              s_axis_last,
  input  logic              s_axis_valid,
  output logic              s_axis_ready,
  output logic [BLK_W-1:0]  o_tx_data,
  output logic [HDR_W-1:0]  o_tx_header,
  output logic              o_tx_data_valid,
  output logic              o_tx_header_valid,
  output logic [SEQ_W-1:0]  o_tx_sequence
);

  localparam int unsigned GAP_W = (MIN_IPG > 1) ? $clog2(MIN_IPG) : 1;

  tx_state_e        state_q, state_d;
  logic [7:0]       res_q, res_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  blk66_t           hold_q, hold_d;
  blk66_t           out_q, out_d;
  logic             vld_q, vld_d;
  logic             ready_q, ready_d;

  logic             pause_c;
  logic             pause_next_c;
  logic             accept_c;
  logic [55:0]      rev_c;
  logic [7:0]       b7_c;
  logic [3:0]       k_c;
  logic [BLK_W-1:0] term_c;
  logic [BLK_W-1:0] skew_c;
  blk66_t           blk_c;

  phy_tx_seq_cnt u_seq_cnt (
    .i_clk          (i_tx_clk),
    .i_rst          (i_tx_rst),
    .o_seq          (o_tx_sequence),
    .o_pause_c      (pause_c),
    .o_pause_next_c (pause_next_c)
  );

  assign accept_c = s_axis_valid & ready_q;
  assign rev_c    = 56'(swap_bytes(s_axis_data));
  assign b7_c     = s_axis_data[7:0];
  assign k_c      = s_axis_last ? 4'($countones(s_axis_keep)) : 4'd8;

  // Short terminate: type, residual, then the k valid bytes of the last beat.
  always_comb begin
    term_c        = '0;
    term_c[7:0]   = BT_TERM[3'(k_c + 4'd1)];
    term_c[15:8]  = res_q;
    for (int i = 0; i < 6; i++) begin
      if (4'(i) < k_c) begin
        term_c[8*i+16 +: 8] = rev_c[8*i +: 8];
      end
    end
  end

  assign skew_c = {rev_c, res_q};

  always_comb begin
    state_d = state_q;
    res_d   = res_q;
    gap_d   = gap_q;
    hold_d  = hold_q;
    out_d   = out_q;
    vld_d   = 1'b1;
    blk_c   = '{hdr: HDR_CTRL, data: BLK_W'(BT_IDLE)};

    if (!pause_c) begin
      case (state_q)
        ST_IDLE: begin
          if (accept_c && (s_axis_keep == 8'hFF)) begin
            blk_c   = '{hdr: HDR_CTRL, data: {rev_c, BT_SOF}};
            res_d   = b7_c;
            state_d = s_axis_last ? ST_TERM1 : ST_DATA;
          end
        end
        ST_DATA: begin
          if (accept_c) begin
            if (!s_axis_last || (k_c == 4'd8)) begin
              blk_c   = '{hdr: HDR_DATA, data: skew_c};
              res_d   = b7_c;
              state_d = s_axis_last ? ST_TERM1 : ST_DATA;
            end else if (k_c == 4'd7) begin
              blk_c   = '{hdr: HDR_DATA, data: skew_c};
              state_d = ST_TERM0;
            end else begin
              blk_c   = '{hdr: HDR_CTRL, data: term_c};
              state_d = ST_GAP;
            end
          end
        end
        ST_TERM0: begin
          blk_c   = '{hdr: HDR_CTRL, data: BLK_W'(BT_TERM[0])};
          state_d = ST_GAP;
        end
        ST_TERM1: begin
          blk_c   = '{hdr: HDR_CTRL, data: BLK_W'({res_q, BT_TERM[1]})};
          state_d = ST_GAP;
        end
        ST_GAP: begin
          if (gap_q == GAP_W'(MIN_IPG - 1)) begin
            gap_d   = '0;
            state_d = ST_IDLE;
          end else begin
            gap_d = gap_q + GAP_W'(1);
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // The block built on the edge into the pause cycle is parked and shown right after it.
    if (pause_c) begin
      out_d = hold_q;
    end else if (pause_next_c) begin
      vld_d  = 1'b0;
      hold_d = blk_c;
    end else begin
      out_d = blk_c;
    end

    ready_d = ((state_d == ST_IDLE) || (state_d == ST_DATA)) && !pause_next_c;
  end

  always_ff @(posedge i_tx_clk or posedge i_tx_rst) begin
    if (i_tx_rst) begin
      state_q <= ST_IDLE;
      res_q   <= '0;
      gap_q   <= '0;
      hold_q  <= '0;
      out_q   <= '0;
      vld_q   <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      res_q   <= res_d;
      gap_q   <= gap_d;
      hold_q  <= hold_d;
      out_q   <= out_d;
      vld_q   <= vld_d;
      ready_q <= ready_d;
    end
  end

  assign s_axis_ready      = ready_q;
  assign o_tx_data         = out_q.data;
  assign o_tx_header       = out_q.hdr;
  assign o_tx_data_valid   = vld_q;
  assign o_tx_header_valid = vld_q;

endmodule

// File: tb/tb_phy_tx.sv
// Scoreboard bench for phy_tx: directed frames push expected blocks, a negedge monitor pops and compares.
module tb_phy_tx;
  import phy_64b66b_pkg::*;

  localparam int unsigned MIN_IPG = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [63:0] s_axis_data = '0;
  logic [7:0]  s_axis_keep = '0;
  logic        s_axis_last = 1'b0;
  logic        s_axis_valid = 1'b0;
  logic        s_axis_ready;
  logic [63:0] o_tx_data;
  logic [1:0]  o_tx_header;
  logic        o_tx_data_valid;
  logic        o_tx_header_valid;
  logic [6:0]  o_tx_sequence;

  always #5 clk = ~clk;

  phy_tx #(.MIN_IPG(MIN_IPG)) dut (
    .i_tx_clk          (clk),
    .i_tx_rst          (rst),
    .s_axis_data       (s_axis_data),
    .s_axis_keep       (s_axis_keep),
    .s_axis_last       (s_axis_last),
    .s_axis_valid      (s_axis_valid),
    .s_axis_ready      (s_axis_ready),
    .o_tx_data         (o_tx_data),
    .o_tx_header       (o_tx_header),
    .o_tx_data_valid   (o_tx_data_valid),
    .o_tx_header_valid (o_tx_header_valid),
    .o_tx_sequence     (o_tx_sequence)
  );

  int checks = 0;
  int errors = 0;
  logic [65:0] exp_q[$];
  int gaps_q[$];

  task automatic chk(input string nm, input logic [79:0] got, input logic [79:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  // Expected block from bytes written in wire order, first byte leftmost.
  function automatic logic [65:0] blk(input logic [1:0] h, input logic [63:0] w);
    logic [63:0] r;
    for (int i = 0; i < 8; i++) r[8*i +: 8] = w[63-8*i -: 8];
    return {h, r};
  endfunction

  function automatic logic is_term(input logic [65:0] b);
    logic t;
    t = 1'b0;
    if (b[65:64] == HDR_CTRL)
      for (int i = 0; i < 8; i++) if (b[7:0] == BT_TERM[i]) t = 1'b1;
    return t;
  endfunction

  function automatic logic [63:0] beat_of(input int base);
    logic [63:0] v;
    for (int i = 0; i < 8; i++) v[63-8*i -: 8] = 8'(base + i);
    return v;
  endfunction

  // Monitor: sequence stepping, pause behaviour, scoreboard and inter-frame gap.
  initial begin
    logic        armed;
    logic [6:0]  prev_seq;
    logic [65:0] prev_out;
    logic [65:0] cur;
    logic        after_term;
    int          idle_run;
    armed = 1'b0; after_term = 1'b0; idle_run = 0; prev_seq = '0; prev_out = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        armed = 1'b0;
        after_term = 1'b0;
      end else begin
        cur = {o_tx_header, o_tx_data};
        if (armed) begin
          chk("seq_step", 80'(o_tx_sequence), 80'((prev_seq == 7'd32) ? 7'd0 : prev_seq + 7'd1));
          if (o_tx_sequence == 7'd32) begin
            chk("pause_flags", 80'({o_tx_data_valid, o_tx_header_valid, s_axis_ready}), 80'(0));
            chk("pause_hold", 80'(cur), 80'(prev_out));
          end
        end
        if (o_tx_data_valid) begin
          if (cur == {HDR_CTRL, 64'(BT_IDLE)}) begin
            if (after_term) idle_run++;
          end else begin
            if (exp_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL unexpected_block: got %h expected none", cur);
            end else begin
              chk("block", 80'(cur), 80'(exp_q.pop_front()));
            end
            if (after_term && cur[65:64] == HDR_CTRL && cur[7:0] == BT_SOF) gaps_q.push_back(idle_run);
            after_term = is_term(cur);
            idle_run = 0;
          end
        end
        prev_seq = o_tx_sequence;
        prev_out = cur;
        armed = 1'b1;
      end
    end
  end

  // Call at a negedge; returns at the negedge after the beat is accepted.
  task automatic send_beat(input logic [63:0] d, input logic [7:0] k, input logic l);
    int n;
    n = 0;
    s_axis_data = d; s_axis_keep = k; s_axis_last = l; s_axis_valid = 1'b1;
    while (!s_axis_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checks++; errors++;
      $display("FAIL ready_timeout: got ready=0 for %0d cycles expected ready=1", n);
    end
    @(negedge clk);
    s_axis_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout: got %0d pending blocks expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    logic [63:0] w;
    logic [63:0] bt;
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_values", 80'({o_tx_data, o_tx_header, o_tx_data_valid, o_tx_header_valid,
                            o_tx_sequence, s_axis_ready}), 80'(0));
    rst = 1'b0;
    repeat (4) @(negedge clk);

    // Frames 16B, 15B, 12B back to back: TERM1, TERM0 and short-TERM endings.
    exp_q.push_back(blk(HDR_CTRL, 64'h71_00_01_02_03_04_05_06));
    exp_q.push_back(blk(HDR_DATA, 64'h07_08_09_0A_0B_0C_0D_0E));
    exp_q.push_back(blk(HDR_CTRL, 64'h99_0F_00_00_00_00_00_00));
    exp_q.push_back(blk(HDR_CTRL, 64'h71_10_11_12_13_14_15_16));
    exp_q.push_back(blk(HDR_DATA, 64'h17_18_19_1A_1B_1C_1D_1E));
    exp_q.push_back(blk(HDR_CTRL, 64'h8E_00_00_00_00_00_00_00));
    exp_q.push_back(blk(HDR_CTRL, 64'h71_20_21_22_23_24_25_26));
    exp_q.push_back(blk(HDR_CTRL, 64'hD4_27_28_29_2A_2B_00_00));
    gaps_q.delete();
    send_beat(64'h00010203_04050607, 8'hFF, 1'b0);
    send_beat(64'h08090A0B_0C0D0E0F, 8'hFF, 1'b1);
    send_beat(64'h10111213_14151617, 8'hFF, 1'b0);
    send_beat(64'h18191A1B_1C1D1E00, 8'hFE, 1'b1);
    send_beat(64'h20212223_24252627, 8'hFF, 1'b0);
    send_beat(64'h28292A2B_00000000, 8'hF0, 1'b1);
    wait_drain();
    repeat (4) @(negedge clk);
    chk("b2b_gap_count", 80'(gaps_q.size()), 80'(2));
    foreach (gaps_q[i]) chk("b2b_idle_blocks", 80'(gaps_q[i]), 80'(MIN_IPG));

    // Partial first beat is dropped, then a single-beat 8B frame.
    send_beat(64'hDEADBEEF_00000001, 8'hF0, 1'b1);
    repeat (6) @(negedge clk);
    exp_q.push_back(blk(HDR_CTRL, 64'h71_30_31_32_33_34_35_36));
    exp_q.push_back(blk(HDR_CTRL, 64'h99_37_00_00_00_00_00_00));
    send_beat(64'h30313233_34353637, 8'hFF, 1'b1);
    wait_drain();
    repeat (4) @(negedge clk);

    // 40-beat frame is guaranteed to straddle at least one pause cycle.
    bt = beat_of(0);
    exp_q.push_back(blk(HDR_CTRL, {BT_SOF, bt[63:8]}));
    for (int j = 1; j < 40; j++) begin
      bt = beat_of(8*j);
      w  = {8'(8*j - 1), bt[63:8]};
      exp_q.push_back(blk(HDR_DATA, w));
    end
    exp_q.push_back(blk(HDR_CTRL, {8'h99, 8'(319), 48'h0}));
    for (int j = 0; j < 40; j++) send_beat(beat_of(8*j), 8'hFF, (j == 39));
    wait_drain();
    repeat (4) @(negedge clk);

    // Reset inside DATA: asynchronous clear, then idles only, then a clean frame.
    exp_q.push_back(blk(HDR_CTRL, 64'h71_50_51_52_53_54_55_56));
    exp_q.push_back(blk(HDR_DATA, 64'h57_58_59_5A_5B_5C_5D_5E));
    send_beat(64'h50515253_54555657, 8'hFF, 1'b0);
    send_beat(64'h58595A5B_5C5D5E5F, 8'hFF, 1'b0);
    repeat (3) @(negedge clk);
    wait_drain();
    #2 rst = 1'b1;
    #1;
    chk("async_reset", 80'({o_tx_data, o_tx_header, o_tx_data_valid, o_tx_header_valid,
                           o_tx_sequence, s_axis_ready}), 80'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    exp_q.push_back(blk(HDR_CTRL, 64'h71_60_61_62_63_64_65_66));
    exp_q.push_back(blk(HDR_CTRL, 64'hD4_67_68_69_6A_6B_00_00));
    send_beat(64'h60616263_64656667, 8'hFF, 1'b0);
    send_beat(64'h68696A6B_00000000, 8'hF0, 1'b1);
    wait_drain();
    repeat (6) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
